rs_bank: RTL and testbench

- Multi-entry reservation station bank; parametrised successor to the single-entry ALU reservation station.
- Holds up to DEPTH in-flight instructions for one functional unit and snoops the CDB for missing operands.
- Dispatches one ready entry per cycle to the FU over a valid/ready handshake.
- Frees an entry when its own tag is broadcast on the CDB. Sits between the issue logic and one ALU/shift FU.

---
 rtl/rs_bank_pkg.sv | 43 ++++
 rtl/rs_prio_enc.sv | 26 ++
 rtl/rs_bank.sv | 176 +++++++++++++++++
 tb/tb_rs_bank.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_bank_pkg.sv
// Shared types for the reservation-station bank: operand/tag words, opcodes, CDB and entry records.
// Tag codes TAG_BASE..TAG_BASE+DEPTH-1 must be consecutive; bank tags are formed by plain addition.
package rs_bank_pkg;

  typedef logic [31:0] word32_t;
  typedef logic [4:0]  rs_tag_t;

  localparam rs_tag_t NO_VAL = 5'd0;
  localparam rs_tag_t ALU_1  = 5'd1;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_PASS
  } alu_op_t;

  typedef enum logic [1:0] {
    SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROT
  } shift_op_t;

  typedef struct packed {
    rs_tag_t tag;
    word32_t val;
  } cdb_t;

  typedef enum logic [1:0] {
    RS_FREE, RS_WAIT, RS_READY, RS_ISSUED
  } rs_entry_state_t;

  typedef struct packed {
    rs_entry_state_t state;
    rs_tag_t         tag1;
    rs_tag_t         tag2;
    word32_t         val1;
    word32_t         val2;
    alu_op_t         alu_op;
    shift_op_t       shift_op;
  } rs_entry_t;

  // An operand wakes up only when it is actually waiting and the bus carries its producer.
  function automatic logic tag_hit(input rs_tag_t tag, input rs_tag_t cdb_tag);
    return (tag != NO_VAL) && (tag == cdb_tag);
  endfunction

endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index finder: returns the one-hot, the binary index and a found flag for a request vector.
module rs_prio_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_index,
  output logic          o_found
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    o_index  = '0;
    o_found  = 1'b0;
    o_onehot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_index = IW'(i);
        o_found = 1'b1;
      end
    end
    if (o_found) o_onehot[o_index] = 1'b1;
  end

endmodule

// File: rtl/rs_bank.sv
// Multi-entry reservation station bank for one ALU/shift FU with CDB snooping and in-order-priority dispatch.
// Optional macro RS_CDB_BYPASS_EN: an allocating write also takes operands broadcast on the CDB that cycle.
module rs_bank
  import rs_bank_pkg::*;
#(
  parameter int      DEPTH    = 4,
  parameter rs_tag_t TAG_BASE = ALU_1,
  localparam int     CNT_W    = $clog2(DEPTH + 1),
  localparam int     IDX_W    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  cdb_t             cdb_i,
  input  logic             write_i,
  input  alu_op_t          alu_opcode_i,
  input  shift_op_t        shift_opcode_i,
  input  rs_tag_t          tag1_i,
  input  rs_tag_t          tag2_i,
  input  word32_t          value1_i,
  input  word32_t          value2_i,
  output logic             full_o,
  output rs_tag_t          alloc_tag_o,
  output logic [CNT_W-1:0] count_o,
  output logic             fu_valid_o,
  input  logic             fu_ready_i,
  output alu_op_t          fu_alu_oper_o,
  output shift_op_t        fu_shift_oper_o,
  output word32_t          fu_rs1_val_o,
  output word32_t          fu_rs2_val_o,
  output rs_tag_t          fu_tag_o
);

  rs_entry_t        r_entry [DEPTH];

  logic [DEPTH-1:0] w_free_vec, w_ready_vec, w_free_oh, w_ready_oh;
  logic [DEPTH-1:0] w_cap1, w_cap2, w_done;
  logic [IDX_W-1:0] w_free_idx, w_ready_idx;
  logic             w_any_free, w_any_ready;
  logic             w_alloc, w_dispatch;
  rs_tag_t          w_new_tag1, w_new_tag2;
  word32_t          w_new_val1, w_new_val2;
  logic [CNT_W-1:0] w_count;

  always_comb begin
    w_free_vec  = '0;
    w_ready_vec = '0;
    w_cap1      = '0;
    w_cap2      = '0;
    w_done      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_free_vec[i]  = (r_entry[i].state == RS_FREE);
      w_ready_vec[i] = (r_entry[i].state == RS_READY);
      w_cap1[i]      = (r_entry[i].state == RS_WAIT) && tag_hit(r_entry[i].tag1, cdb_i.tag);
      w_cap2[i]      = (r_entry[i].state == RS_WAIT) && tag_hit(r_entry[i].tag2, cdb_i.tag);
      w_done[i]      = (r_entry[i].state == RS_ISSUED) &&
                       (cdb_i.tag == rs_tag_t'(TAG_BASE + rs_tag_t'(i)));
    end
  end

  rs_prio_enc #(.N(DEPTH), .IW(IDX_W)) u_free_sel (
    .i_req    (w_free_vec),
    .o_onehot (w_free_oh),
    .o_index  (w_free_idx),
    .o_found  (w_any_free)
  );

  rs_prio_enc #(.N(DEPTH), .IW(IDX_W)) u_ready_sel (
    .i_req    (w_ready_vec),
    .o_onehot (w_ready_oh),
    .o_index  (w_ready_idx),
    .o_found  (w_any_ready)
  );

  // FU handshake: fu_valid_o marks a stable offer of the lowest READY entry; a transfer
  // happens on any edge where fu_valid_o && fu_ready_i, and the offer may only change
  // while stalled if a lower-index entry turns READY.
  assign w_alloc    = write_i && w_any_free;
  assign w_dispatch = w_any_ready && fu_ready_i;

`ifdef RS_CDB_BYPASS_EN
  always_comb begin
    w_new_tag1 = tag1_i;
    w_new_val1 = value1_i;
    w_new_tag2 = tag2_i;
    w_new_val2 = value2_i;
    if (tag_hit(tag1_i, cdb_i.tag)) begin
      w_new_tag1 = NO_VAL;
      w_new_val1 = cdb_i.val;
    end
    if (tag_hit(tag2_i, cdb_i.tag)) begin
      w_new_tag2 = NO_VAL;
      w_new_val2 = cdb_i.val;
    end
  end
`else
  assign w_new_tag1 = tag1_i;
  assign w_new_val1 = value1_i;
  assign w_new_tag2 = tag2_i;
  assign w_new_val2 = value2_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= '{state: RS_FREE, tag1: NO_VAL, tag2: NO_VAL, val1: '0, val2: '0,
                        alu_op: ALU_ADD, shift_op: SHIFT_SLL};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        case (r_entry[i].state)
          RS_FREE: begin
            if (w_alloc && w_free_oh[i]) begin
              r_entry[i].state    <= (w_new_tag1 == NO_VAL && w_new_tag2 == NO_VAL) ?
                                     RS_READY : RS_WAIT;
              r_entry[i].tag1     <= w_new_tag1;
              r_entry[i].tag2     <= w_new_tag2;
              r_entry[i].val1     <= w_new_val1;
              r_entry[i].val2     <= w_new_val2;
              r_entry[i].alu_op   <= alu_opcode_i;
              r_entry[i].shift_op <= shift_opcode_i;
            end
          end
          RS_WAIT: begin
            if (w_cap1[i]) begin
              r_entry[i].tag1 <= NO_VAL;
              r_entry[i].val1 <= cdb_i.val;
            end
            if (w_cap2[i]) begin
              r_entry[i].tag2 <= NO_VAL;
              r_entry[i].val2 <= cdb_i.val;
            end
            if ((w_cap1[i] || r_entry[i].tag1 == NO_VAL) &&
                (w_cap2[i] || r_entry[i].tag2 == NO_VAL)) begin
              r_entry[i].state <= RS_READY;
            end
          end
          RS_READY: begin
            if (w_dispatch && w_ready_oh[i]) r_entry[i].state <= RS_ISSUED;
          end
          RS_ISSUED: begin
            if (w_done[i]) r_entry[i].state <= RS_FREE;
          end
          default: r_entry[i].state <= RS_FREE;
        endcase
      end
    end
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count = w_count + CNT_W'(!w_free_vec[i]);
    end
  end

  assign count_o     = w_count;
  assign full_o      = !w_any_free;
  assign alloc_tag_o = w_any_free ? rs_tag_t'(TAG_BASE + rs_tag_t'(w_free_idx)) : NO_VAL;

  always_comb begin
    fu_valid_o      = w_any_ready;
    fu_alu_oper_o   = ALU_ADD;
    fu_shift_oper_o = SHIFT_SLL;
    fu_rs1_val_o    = '0;
    fu_rs2_val_o    = '0;
    fu_tag_o        = NO_VAL;
    if (w_any_ready) begin
      fu_alu_oper_o   = r_entry[w_ready_idx].alu_op;
      fu_shift_oper_o = r_entry[w_ready_idx].shift_op;
      fu_rs1_val_o    = r_entry[w_ready_idx].val1;
      fu_rs2_val_o    = r_entry[w_ready_idx].val2;
      fu_tag_o        = rs_tag_t'(TAG_BASE + rs_tag_t'(w_ready_idx));
    end
  end

endmodule

// File: tb/tb_rs_bank.sv
// Self-checking bench for rs_bank: directed scenarios followed by random traffic against an
// array-based model of the bank's occupancy, pending operands and dispatch order.
module tb_rs_bank;
  import rs_bank_pkg::*;

  localparam int      DEPTH   = 4;
  localparam rs_tag_t TB_BASE = ALU_1;
  localparam int      CNT_W   = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset_ni;
  cdb_t             cdb;
  logic             write;
  alu_op_t          alu_op;
  shift_op_t        shift_op;
  rs_tag_t          tag1, tag2;
  word32_t          value1, value2;
  logic             full;
  rs_tag_t          alloc_tag;
  logic [CNT_W-1:0] count;
  logic             fu_valid;
  logic             fu_ready;
  alu_op_t          fu_alu;
  shift_op_t        fu_shift;
  word32_t          fu_rs1, fu_rs2;
  rs_tag_t          fu_tag;

  int checks = 0;
  int errors = 0;

  rs_bank #(.DEPTH(DEPTH), .TAG_BASE(TB_BASE)) dut (
    .clk_i           (clk),
    .reset_ni        (reset_ni),
    .cdb_i           (cdb),
    .write_i         (write),
    .alu_opcode_i    (alu_op),
    .shift_opcode_i  (shift_op),
    .tag1_i          (tag1),
    .tag2_i          (tag2),
    .value1_i        (value1),
    .value2_i        (value2),
    .full_o          (full),
    .alloc_tag_o     (alloc_tag),
    .count_o         (count),
    .fu_valid_o      (fu_valid),
    .fu_ready_i      (fu_ready),
    .fu_alu_oper_o   (fu_alu),
    .fu_shift_oper_o (fu_shift),
    .fu_rs1_val_o    (fu_rs1),
    .fu_rs2_val_o    (fu_rs2),
    .fu_tag_o        (fu_tag)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Reference model: occupancy, "sent to FU" flag, pending producer tags and captured data.
  bit        m_busy [DEPTH];
  bit        m_sent [DEPTH];
  rs_tag_t   m_t1   [DEPTH];
  rs_tag_t   m_t2   [DEPTH];
  word32_t   m_v1   [DEPTH];
  word32_t   m_v2   [DEPTH];
  alu_op_t   m_alu  [DEPTH];
  shift_op_t m_sh   [DEPTH];

  function automatic int m_first_free();
    for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int m_presented();
    for (int i = 0; i < DEPTH; i++)
      if (m_busy[i] && !m_sent[i] && m_t1[i] == NO_VAL && m_t2[i] == NO_VAL) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_busy[i] = 0;
      m_sent[i] = 0;
      m_t1[i]   = NO_VAL;
      m_t2[i]   = NO_VAL;
      m_v1[i]   = '0;
      m_v2[i]   = '0;
    end
  endtask

  // Scoreboard comparison
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    int ff = m_first_free();
    int pr = m_presented();
    check("full", 32'(full), 32'(ff < 0));
    check("count", 32'(count), 32'(m_count()));
    check("alloc_tag", 32'(alloc_tag), (ff < 0) ? 32'(NO_VAL) : 32'(TB_BASE) + 32'(ff));
    check("fu_valid", 32'(fu_valid), 32'(pr >= 0));
    check("fu_tag", 32'(fu_tag), (pr < 0) ? 32'(NO_VAL) : 32'(TB_BASE) + 32'(pr));
    check("fu_rs1", fu_rs1, (pr < 0) ? 32'd0 : m_v1[pr]);
    check("fu_rs2", fu_rs2, (pr < 0) ? 32'd0 : m_v2[pr]);
    check("fu_alu", 32'(fu_alu), (pr < 0) ? 32'd0 : 32'(m_alu[pr]));
    check("fu_shift", 32'(fu_shift), (pr < 0) ? 32'd0 : 32'(m_sh[pr]));
  endtask

  // Model update for one edge, computed from the pre-edge snapshot and the driven inputs.
  task automatic model_edge();
    int ff = m_first_free();
    int pr = m_presented();
    for (int i = 0; i < DEPTH; i++) begin
      if (m_busy[i] && m_sent[i] && cdb.tag == rs_tag_t'(TB_BASE + i)) begin
        m_busy[i] = 0;
        m_sent[i] = 0;
      end else if (m_busy[i] && !m_sent[i]) begin
        if (m_t1[i] != NO_VAL && m_t1[i] == cdb.tag) begin m_t1[i] = NO_VAL; m_v1[i] = cdb.val; end
        if (m_t2[i] != NO_VAL && m_t2[i] == cdb.tag) begin m_t2[i] = NO_VAL; m_v2[i] = cdb.val; end
      end
    end
    if (pr >= 0 && fu_ready) m_sent[pr] = 1;
    if (write && ff >= 0) begin
      m_busy[ff] = 1;
      m_sent[ff] = 0;
      m_t1[ff]   = tag1;
      m_t2[ff]   = tag2;
      m_v1[ff]   = value1;
      m_v2[ff]   = value2;
      m_alu[ff]  = alu_op;
      m_sh[ff]   = shift_op;
`ifdef RS_CDB_BYPASS_EN
      if (tag1 != NO_VAL && tag1 == cdb.tag) begin m_t1[ff] = NO_VAL; m_v1[ff] = cdb.val; end
      if (tag2 != NO_VAL && tag2 == cdb.tag) begin m_t2[ff] = NO_VAL; m_v2[ff] = cdb.val; end
`endif
    end
  endtask

  // Driver tasks: inputs change on the falling edge, outputs are checked before the rising edge.
  task automatic apply(input bit w, input rs_tag_t t1, input rs_tag_t t2,
                       input word32_t v1, input word32_t v2,
                       input rs_tag_t ctag, input word32_t cval, input bit rdy);
    write    = w;
    tag1     = t1;
    tag2     = t2;
    value1   = v1;
    value2   = v2;
    alu_op   = alu_op_t'($urandom_range(0, 7));
    shift_op = shift_op_t'($urandom_range(0, 3));
    cdb.tag  = ctag;
    cdb.val  = cval;
    fu_ready = rdy;
    #1;
  endtask

  task automatic tick();
    check_outputs();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    apply(0, NO_VAL, NO_VAL, 0, 0, NO_VAL, 0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle(0);
    reset_ni = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_ni = 1'b1;
    m_clear();
  endtask

  function automatic rs_tag_t pick_tag(input bit for_cdb);
    int r = $urandom_range(for_cdb ? 2 : 0, 10);
    if (r < 3) return NO_VAL;
    if (r < 7) return rs_tag_t'(20 + r - 3);
    return rs_tag_t'(TB_BASE + (r - 7));
  endfunction

  initial begin
    reset_ni = 1'b1;
    idle(0);

    // Reset state
    do_reset();
    idle(0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_fu_valid", 32'(fu_valid), 32'd0);
    check("rst_alloc_tag", 32'(alloc_tag), 32'(TB_BASE));
    check("rst_fu_tag", 32'(fu_tag), 32'(NO_VAL));
    tick();

    // Ready write: dispatched the cycle after the write, freed by its own tag
    apply(1, NO_VAL, NO_VAL, 5, 7, NO_VAL, 0, 1);
    tick();
    idle(1);
    check("rw_valid", 32'(fu_valid), 32'd1);
    check("rw_rs1", fu_rs1, 32'd5);
    check("rw_rs2", fu_rs2, 32'd7);
    check("rw_tag", 32'(fu_tag), 32'(TB_BASE));
    tick();
    apply(0, NO_VAL, NO_VAL, 0, 0, TB_BASE, 32'h77, 1);
    check("rw_count_issued", 32'(count), 32'd1);
    tick();
    idle(1);
    check("rw_count_done", 32'(count), 32'd0);
    tick();

    // Wakeup on two different producers, then on a shared producer
    apply(1, 5'd20, 5'd21, 32'hdead, 32'hbeef, NO_VAL, 0, 1);
    tick();
    apply(0, NO_VAL, NO_VAL, 0, 0, 5'd20, 32'h10, 1);
    check("wk_wait1", 32'(fu_valid), 32'd0);
    tick();
    apply(0, NO_VAL, NO_VAL, 0, 0, 5'd21, 32'h20, 1);
    check("wk_wait2", 32'(fu_valid), 32'd0);
    tick();
    idle(1);
    check("wk_valid", 32'(fu_valid), 32'd1);
    check("wk_rs1", fu_rs1, 32'h10);
    check("wk_rs2", fu_rs2, 32'h20);
    tick();
    apply(0, NO_VAL, NO_VAL, 0, 0, TB_BASE, 0, 1);
    tick();
    apply(1, 5'd20, 5'd20, 1, 2, NO_VAL, 0, 1);
    tick();
    apply(0, NO_VAL, NO_VAL, 0, 0, 5'd20, 32'h33, 1);
    tick();
    idle(1);
    check("wk_same_valid", 32'(fu_valid), 32'd1);
    check("wk_same_rs1", fu_rs1, 32'h33);
    check("wk_same_rs2", fu_rs2, 32'h33);
    tick();
    apply(0, NO_VAL, NO_VAL, 0, 0, TB_BASE, 0, 1);
    tick();

    // Full and backpressure
    for (int i = 0; i < DEPTH; i++) begin
      apply(1, NO_VAL, NO_VAL, word32_t'(i + 1), word32_t'(i + 100), NO_VAL, 0, 0);
      tick();
    end
    idle(0);
    check("full_flag", 32'(full), 32'd1);
    check("full_alloc_tag", 32'(alloc_tag), 32'(NO_VAL));
    check("full_count", 32'(count), 32'(DEPTH));
    tick();
    apply(1, NO_VAL, NO_VAL, 32'hbad, 32'hbad, NO_VAL, 0, 0);
    tick();
    idle(0);
    check("drop_count", 32'(count), 32'(DEPTH));
    check("stall_tag", 32'(fu_tag), 32'(TB_BASE));
    check("stall_rs1", fu_rs1, 32'd1);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      idle(1);
      tick();
    end
    for (int i = 0; i < DEPTH; i++) begin
      apply(0, NO_VAL, NO_VAL, 0, 0, rs_tag_t'(TB_BASE + i), 0, 1);
      tick();
    end
    idle(1);
    check("drain_count", 32'(count), 32'd0);
    tick();

    // Priority: entries 1 and 2 wake together, entry 1 goes first
    apply(1, 5'd21, NO_VAL, 10, 11, NO_VAL, 0, 1);
    tick();
    apply(1, 5'd22, NO_VAL, 12, 13, NO_VAL, 0, 1);
    tick();
    apply(1, NO_VAL, 5'd22, 14, 15, NO_VAL, 0, 1);
    tick();
    apply(0, NO_VAL, NO_VAL, 0, 0, 5'd22, 32'h55, 1);
    tick();
    idle(1);
    check("prio_first", 32'(fu_tag), 32'(TB_BASE) + 32'd1);
    tick();
    idle(1);
    check("prio_second", 32'(fu_tag), 32'(TB_BASE) + 32'd2);
    check("prio_second_rs2", fu_rs2, 32'h55);
    tick();

    // Allocation in the same cycle as the producer's broadcast
    do_reset();
    apply(1, 5'd23, NO_VAL, 0, 4, 5'd23, 32'd9, 0);
    tick();
    idle(0);
`ifdef RS_CDB_BYPASS_EN
    check("byp_valid", 32'(fu_valid), 32'd1);
    check("byp_rs1", fu_rs1, 32'd9);
`else
    check("byp_valid", 32'(fu_valid), 32'd0);
    check("byp_count", 32'(count), 32'd1);
`endif
    tick();

    // Random traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      apply(bit'($urandom_range(0, 1)), pick_tag(0), pick_tag(0), $urandom, $urandom,
            pick_tag(1), $urandom, $urandom_range(0, 3) != 0);
      tick();
    end

    // Reset with entries in flight, then a late completion broadcast is ignored
    for (int i = 0; i < DEPTH; i++) begin
      apply(1, NO_VAL, NO_VAL, 1, 1, NO_VAL, 0, 1);
      tick();
    end
    do_reset();
    apply(0, NO_VAL, NO_VAL, 0, 0, TB_BASE, 0, 0);
    check("midrst_count", 32'(count), 32'd0);
    tick();
    idle(0);
    check("midrst_after_cdb", 32'(count), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
